// File: rtl/reset_sequencer.sv
// Staged reset release: three request sources are synchronized and merged,
// then three active-low reset stages are released in order after a quiet hold.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 10000,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fpga_reset_n_debounced,
  input  logic       h2f_reset,
  input  logic       src_reset_n,
  output logic [2:0] rst_n_stage,
  output logic       seq_done,
  output logic [7:0] reset_count
);

  if (CNT_WIDTH < 1 || CNT_WIDTH > 62) begin : g_bad_width
    $error("reset_sequencer: CNT_WIDTH out of range");
  end
  if (HOLD_CYCLES < 1 ||
      longint'(HOLD_CYCLES) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES out of range");
  end
  if (STAGE_GAP < 1 ||
      longint'(STAGE_GAP) >= (longint'(1) << CNT_WIDTH)) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP out of range");
  end

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic [CNT_WIDTH-1:0] gap_cnt;
  logic [1:0]           fpga_sync;
  logic [1:0]           h2f_sync;
  logic [1:0]           src_sync;
  logic                 req_s;

  // Synchronizers reset to the "request asserted" level so the
  // sequence always starts from a full hold after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fpga_sync <= 2'b00;
      h2f_sync  <= 2'b11;
      src_sync  <= 2'b00;
    end else begin
      fpga_sync <= {fpga_sync[0], fpga_reset_n_debounced};
      h2f_sync  <= {h2f_sync[0], h2f_reset};
      src_sync  <= {src_sync[0], src_reset_n};
    end
  end

  assign req_s = ~fpga_sync[1] | h2f_sync[1] | ~src_sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ASSERT;
      rst_n_stage <= 3'b000;
      seq_done    <= 1'b0;
      hold_cnt    <= '0;
      gap_cnt     <= '0;
      reset_count <= 8'd0;
    end else begin
      unique case (state)
        ASSERT: begin
          rst_n_stage <= 3'b000;
          seq_done    <= 1'b0;
          gap_cnt     <= '0;
          if (req_s) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state       <= RELEASE;
            rst_n_stage <= 3'b001;
            hold_cnt    <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (req_s) begin
            state       <= ASSERT;
            rst_n_stage <= 3'b000;
            seq_done    <= 1'b0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            if (reset_count != 8'hFF)
              reset_count <= reset_count + 8'd1;
          end else if (state == RELEASE) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              if (!rst_n_stage[1]) begin
                rst_n_stage[1] <= 1'b1;
              end else begin
                rst_n_stage[2] <= 1'b1;
                seq_done       <= 1'b1;
                state          <= RUN;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end else begin
            rst_n_stage <= 3'b111;
            seq_done    <= 1'b1;
          end
        end
        default: begin
          state       <= ASSERT;
          rst_n_stage <= 3'b000;
          seq_done    <= 1'b0;
          hold_cnt    <= '0;
          gap_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10000: consecutive quiet cycles required before the first stage release (100 us at 100 MHz).
REQ-002 SHALL have parameter STAGE_GAP, default 16: cycles between successive stage releases.
REQ-003 SHALL have parameter CNT_WIDTH, default 32: width of the hold and gap counters.
REQ-004 SHALL have port clk, input, 1: system clock, 100 MHz.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have port fpga_reset_n_debounced, input, 1: debounced board button, active-low, asynchronous to clk.
REQ-007 SHALL have port h2f_reset, input, 1: HPS-to-FPGA reset, active-high, asynchronous to clk.
REQ-008 SHALL have port src_reset_n, input, 1: auxiliary source, active-low, asynchronous to clk.
REQ-009 SHALL have port rst_n_stage, output, 3: staged resets, active-low; bit 0 releases first.
REQ-010 SHALL have port seq_done, output, 1: high while all stages are released.
REQ-011 SHALL have port reset_count, output, 8: count of reset events.

Function
REQ-012 SHALL pass each asynchronous input through its own 2-flop synchronizer.
REQ-013 SHALL form req_s = ~sync(fpga_reset_n_debounced) | sync(h2f_reset) | ~sync(src_reset_n), combinational from the synchronizer outputs.
REQ-014 SHALL implement FSM states ASSERT, RELEASE and RUN.
REQ-015 In ASSERT: rst_n_stage = 3'b000 and seq_done = 0.
REQ-016 In ASSERT: hold_cnt increments each cycle req_s = 0 and clears to 0 on any cycle req_s = 1.
REQ-017 In ASSERT: when req_s = 0 and hold_cnt == HOLD_CYCLES-1, next state SHALL be RELEASE, with rst_n_stage[0] = 1 and gap_cnt = 0 on the same edge.
REQ-018 In RELEASE: gap_cnt increments each cycle.
REQ-019 In RELEASE: when gap_cnt == STAGE_GAP-1 and rst_n_stage[1] = 0, rst_n_stage[1] SHALL rise and gap_cnt SHALL clear.
REQ-020 In RELEASE: when gap_cnt == STAGE_GAP-1 and rst_n_stage[1] = 1, rst_n_stage[2] SHALL rise, seq_done SHALL rise and the state SHALL become RUN, all on that edge.
REQ-021 In RUN: outputs SHALL hold 3'b111 and seq_done = 1.
REQ-022 When req_s = 1 in RELEASE or RUN, the next edge SHALL force the state to ASSERT, rst_n_stage = 000, seq_done = 0 and both counters to 0.
REQ-023 Stage assertion on a request SHALL be simultaneous for all bits; release SHALL always follow the order 0, 1, 2.
REQ-024 reset_count SHALL increment by 1 on each RELEASE/RUN -> ASSERT transition and saturate at 255.
REQ-025 A req_s pulse of any length, including 1 cycle, during RELEASE or RUN SHALL restart the full sequence.
REQ-026 Requests glitching during ASSERT SHALL only restart hold_cnt.
REQ-027 Simultaneous requests from several sources SHALL count as one event.
REQ-028 Outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-029 Legal parameters SHALL be 1 <= HOLD_CYCLES < 2^CNT_WIDTH and 1 <= STAGE_GAP < 2^CNT_WIDTH.
REQ-030 Illegal parameters SHALL raise an elaboration-time error.
REQ-031 End-to-end latency: with inputs idle, rst_n_stage[0] SHALL rise on edge HOLD_CYCLES+2, counting the first edge sampling reset = 0 as edge 1.

Reset
REQ-032 While reset = 1, the block SHALL load state ASSERT, rst_n_stage = 000, seq_done = 0, hold_cnt = gap_cnt = 0 and reset_count = 0.
REQ-033 While reset = 1, synchronizer flops SHALL load the asserted-request values: fpga_reset_n_debounced and src_reset_n syncs to 0, h2f_reset sync to 1.
REQ-034 Reset asserted mid-sequence SHALL take effect at the next edge.
REQ-035 Reset asserted mid-sequence SHALL leave reset_count cleared, not incremented.

Verification (HOLD_CYCLES=100, STAGE_GAP=4)
REQ-036 Power-up: release reset, inputs idle -> rst_n_stage[0] rises edge 102, bit 1 edge 106, bit 2 and seq_done edge 110; reset_count = 0.
REQ-037 Button press in RUN: fpga_reset_n_debounced low for 1 cycle -> within 3 edges rst_n_stage = 000 and reset_count = 1; full sequence repeats 100/4/4.
REQ-038 Bouncing source in ASSERT: h2f_reset pulses every 50 cycles for 500 cycles -> rst_n_stage stays 000 until 100 quiet cycles after the last sync'd pulse; reset_count unchanged.
REQ-039 Interrupt in RELEASE: src_reset_n low while only bit 0 is released -> stages 000 next edge after req_s; reset_count increments; bit 1 never glitches high.
REQ-040 Saturation: force 300 RUN->ASSERT events -> reset_count reads 255; synchronous reset mid-RELEASE -> all outputs 0 on next edge, reset_count = 0.
